// File: rtl/arbiter_rr_atc_if.sv
// Request/grant bundle between requesters and the round-robin access-time arbiter (lock line with ARB_LOCK_EN).
// Latency: none, wires only.
// Backpressure: none; requesters hold req until granted and done.
interface arbiter_rr_atc_if #(
    parameter int NUM_REQ = 3,
    parameter int ATC_W   = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               cfg_we;
    logic [ATC_W-1:0]   cfg_atc;
`ifdef ARB_LOCK_EN
    logic               lock;
`endif
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               timeout;

`ifdef ARB_LOCK_EN
    modport master (output req, cfg_we, cfg_atc, lock, input grant, grant_id, busy, timeout);
    modport slave  (input req, cfg_we, cfg_atc, lock, output grant, grant_id, busy, timeout);
`else
    modport master (output req, cfg_we, cfg_atc, input grant, grant_id, busy, timeout);
    modport slave  (input req, cfg_we, cfg_atc, output grant, grant_id, busy, timeout);
`endif
endinterface

// File: rtl/arbiter_rr_atc.sv
// Round-robin arbiter with programmable access time; ARB_LOCK_EN adds a lock input that freezes preemption.
// Latency: req sampled on one edge yields a registered grant from that edge; one dead cycle between holders.
// Backpressure: a holder keeps the grant while req stays high, preempted after atc cycles only under contention.
module arbiter_rr_atc #(
    parameter int NUM_REQ     = 3,
    parameter int ATC_W       = 4,
    parameter int ATC_DEFAULT = 4
) (
    input  logic              clk,
    input  logic              reset,
    arbiter_rr_atc_if.slave   bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t           state;
    logic [ATC_W-1:0] atc_reg;
    logic [ATC_W-1:0] cnt;
    logic [ID_W-1:0]  rr_ptr;

    logic             pick_vld;
    logic [ID_W-1:0]  pick_idx;
    logic             holder_req;
    logic             other_req;
    logic             expire;
    logic             lock_hold;
    int               idx;

    assign holder_req = |(bus.req & bus.grant);
    assign other_req  = |(bus.req & ~bus.grant);
    assign expire     = (atc_reg != '0) && (cnt == ATC_W'(1));

`ifdef ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Scan starts just past the last winner, so the previous holder ranks lowest.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_vld && bus.req[idx[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
            bus.timeout  <= 1'b0;
            atc_reg      <= ATC_W'(ATC_DEFAULT);
            cnt          <= '0;
            rr_ptr       <= ID_W'(NUM_REQ - 1);
        end else begin
            bus.timeout <= 1'b0;
            if (bus.cfg_we) atc_reg <= bus.cfg_atc;
            case (state)
                IDLE, RELEASE: begin
                    if (pick_vld) begin
                        bus.grant    <= ONE << pick_idx;
                        bus.grant_id <= pick_idx;
                        bus.busy     <= 1'b1;
                        cnt          <= atc_reg;
                        rr_ptr       <= pick_idx;
                        state        <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (!holder_req) begin
                        bus.grant <= '0;
                        bus.busy  <= 1'b0;
                        state     <= RELEASE;
                    end else if (lock_hold) begin
                        cnt <= cnt;
                    end else if (expire && other_req) begin
                        bus.grant   <= '0;
                        bus.busy    <= 1'b0;
                        bus.timeout <= 1'b1;
                        state       <= RELEASE;
                    end else if (expire) begin
                        // Uncontended holder simply gets a fresh budget.
                        cnt <= atc_reg;
                    end else if (atc_reg != '0) begin
                        cnt <= cnt - ATC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arbiter_rr_atc.sv
// Randomized and directed bench for arbiter_rr_atc against a holder/elapsed-time reference model.
module tb_arbiter_rr_atc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    arbiter_rr_atc_if #(.NUM_REQ(3), .ATC_W(4)) bus ();

    arbiter_rr_atc #(.NUM_REQ(3), .ATC_W(4), .ATC_DEFAULT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the bus, how long it has held it, and its budget.
    int m_holder, m_last, m_atc, m_budget, m_elapsed;
    bit m_to;

    task automatic model_reset();
        m_holder = -1; m_last = 2; m_atc = 4; m_budget = 0; m_elapsed = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [2:0] r, input logic we, input logic [3:0] a);
        logic [2:0] others;
        bit was_free;
        was_free = (m_holder < 0);
        m_to = 0;
        if (!was_free) begin
            others = r;
            others[m_holder] = 1'b0;
            if (!r[m_holder]) begin
                m_holder = -1;
            end else if (m_atc != 0) begin
                if (m_elapsed + 1 == m_budget) begin
                    if (others != 3'b000) begin
                        m_holder = -1;
                        m_to = 1;
                    end else begin
                        m_budget = m_atc;
                        m_elapsed = 0;
                    end
                end else begin
                    m_elapsed++;
                end
            end
        end else begin
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (m_last + k) % 3;
                if (m_holder < 0 && r[i]) begin
                    m_holder = i; m_last = i; m_budget = m_atc; m_elapsed = 0;
                end
            end
        end
        if (we) m_atc = int'(a);
    endtask

    function automatic logic [2:0] exp_grant();
        logic [2:0] g;
        g = 3'b000;
        if (m_holder >= 0) g[m_holder] = 1'b1;
        return g;
    endfunction

    task automatic cyc(input logic [2:0] r, input logic we, input logic [3:0] a);
        @(negedge clk);
        bus.req = r; bus.cfg_we = we; bus.cfg_atc = a;
        model_step(r, we, a);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.req = 3'b000; bus.cfg_we = 1'b0; bus.cfg_atc = 4'd0;
        reset = 1'b1;
        model_reset();
        #12;
        checks++;
        if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: grant=%b busy=%b to=%b id=%0d expected 000/0/0/0",
                     bus.grant, bus.busy, bus.timeout, bus.grant_id);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            cyc(3'b000, 1'b0, 4'd0);
            checks++;
            if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: grant=%b busy=%b to=%b expected 000/0/0",
                         c, bus.grant, bus.busy, bus.timeout);
            end
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 8; c++) begin
            cyc((c < 3) ? 3'b001 : 3'b000, 1'b0, 4'd0);
            checks++;
            if (bus.grant !== exp_grant() || bus.busy !== (m_holder >= 0) || bus.timeout !== m_to ||
                (m_holder >= 0 && bus.grant_id !== 2'(m_holder))) begin
                errors++;
                $display("FAIL single cyc %0d: grant=%b busy=%b to=%b id=%0d expected grant=%b to=%b",
                         c, bus.grant, bus.busy, bus.timeout, bus.grant_id, exp_grant(), m_to);
            end
            if (c == 0) begin
                checks++;
                if (bus.grant !== 3'b001) begin
                    errors++;
                    $display("FAIL single_latency: grant=%b expected 001", bus.grant);
                end
            end
        end
    endtask

    task automatic test_contention(input logic [2:0] r, input int ncyc);
        int tos;
        tos = 0;
        for (int c = 0; c < ncyc; c++) begin
            cyc(r, 1'b0, 4'd0);
            if (bus.timeout === 1'b1) tos++;
            checks++;
            if (bus.grant !== exp_grant() || bus.busy !== (m_holder >= 0) || bus.timeout !== m_to ||
                (m_holder >= 0 && bus.grant_id !== 2'(m_holder))) begin
                errors++;
                $display("FAIL contention %b cyc %0d: grant=%b busy=%b to=%b id=%0d expected grant=%b to=%b",
                         r, c, bus.grant, bus.busy, bus.timeout, bus.grant_id, exp_grant(), m_to);
            end
        end
        // With 4-cycle grants and one dead cycle, one timeout every 5 cycles.
        checks++;
        if (tos < (ncyc / 5) - 1) begin
            errors++;
            $display("FAIL contention_timeouts %b: saw %0d expected at least %0d", r, tos, (ncyc / 5) - 1);
        end
        for (int c = 0; c < 3; c++) cyc(3'b000, 1'b0, 4'd0);
    endtask

    task automatic test_cfg();
        bit busy_q[$];
        int run, runs[$];
        bit seen;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            cyc(3'b011, (c == 1), 4'd2);
            busy_q.push_back(bus.busy);
            checks++;
            if (bus.grant !== exp_grant() || bus.timeout !== m_to) begin
                errors++;
                $display("FAIL cfg cyc %0d: grant=%b to=%b expected grant=%b to=%b",
                         c, bus.grant, bus.timeout, exp_grant(), m_to);
            end
        end
        run = 0;
        foreach (busy_q[i]) begin
            if (busy_q[i]) run++;
            else if (run != 0) begin runs.push_back(run); run = 0; end
        end
        checks++;
        if (runs.size() < 2 || runs[0] != 4 || runs[1] != 2) begin
            errors++;
            $display("FAIL cfg_lengths: runs=%0d first=%0d second=%0d expected 4 then 2",
                     runs.size(), (runs.size() > 0) ? runs[0] : -1, (runs.size() > 1) ? runs[1] : -1);
        end
        for (int c = 0; c < 3; c++) cyc(3'b000, (c == 0), 4'd0);
        for (int c = 0; c < 30; c++) begin
            cyc(3'b011, 1'b0, 4'd0);
            checks++;
            if (bus.timeout !== 1'b0 || bus.grant !== exp_grant()) begin
                errors++;
                $display("FAIL atc_zero cyc %0d: grant=%b to=%b expected grant=%b to=0",
                         c, bus.grant, bus.timeout, exp_grant());
            end
        end
        checks++;
        if (bus.grant !== 3'b001) begin
            errors++;
            $display("FAIL atc_zero_hold: grant=%b expected 001", bus.grant);
        end
        for (int c = 0; c < 3; c++) cyc(3'b000, (c == 2), 4'd4);
    endtask

    task automatic test_random();
        logic [2:0] r;
        logic we;
        logic [3:0] a;
        r = 3'b000;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            we = ($urandom_range(0, 15) == 0);
            a  = 4'($urandom_range(1, 6));
            cyc(r, we, a);
            checks++;
            if (bus.grant !== exp_grant() || bus.busy !== (m_holder >= 0) || bus.timeout !== m_to ||
                (m_holder >= 0 && bus.grant_id !== 2'(m_holder)) || $countones(bus.grant) > 1) begin
                errors++;
                $display("FAIL random cyc %0d: req=%b grant=%b busy=%b to=%b id=%0d expected grant=%b to=%b",
                         c, r, bus.grant, bus.busy, bus.timeout, bus.grant_id, exp_grant(), m_to);
            end
        end
        for (int c = 0; c < 3; c++) cyc(3'b000, (c == 0), 4'd4);
    endtask

    task automatic test_reset_mid();
        cyc(3'b100, 1'b0, 4'd0);
        cyc(3'b100, 1'b0, 4'd0);
        checks++;
        if (bus.grant !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_pre: grant=%b expected 100", bus.grant);
        end
        #2;
        bus.req = 3'b000;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.grant !== 3'b000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: grant=%b busy=%b to=%b expected 000/0/0",
                     bus.grant, bus.busy, bus.timeout);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(3'b111, 1'b0, 4'd0);
        checks++;
        if (bus.grant !== 3'b001 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_rrptr: grant=%b id=%0d expected 001/0", bus.grant, bus.grant_id);
        end
    endtask

    initial begin
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_single();
        test_contention(3'b011, 25);
        test_contention(3'b111, 30);
        test_contention(3'b110, 20);
        test_contention(3'b101, 20);
        test_cfg();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
